key_ctrl: RTL and testbench
===========================

// Module: key_ctrl
// PURPOSE
//  Downstream consumer of the debounced single-cycle key pulses (oKey1..3 of the key stage).
//  Turns them into a user-adjustable parameter set:
//   - key1 single-click advances the mode.
//   - key1 double-click restores defaults.
//   - key2/key3 step the current mode's value up/down.
//  Feeds registered mode/value and change strobes to the downstream datapath.
// PARAMETERS
//  NUM_MODES   4           number of modes / parameter slots (>=2)
//  MODE_W      2           mode width, = $clog2(NUM_MODES)
//  VAL_W       8           width of each parameter value
//  VAL_MAX     255         saturation ceiling for values (<= 2**VAL_W-1)
//  VAL_DEF     128         reset/restore value of every slot
//  STEP        1           increment/decrement amount per press
//  DCLK_WIN    15_000_000  double-click window in sys_clk cycles (0.3 s @ 50 MHz), >=2
// PORTS
//  sys_clk     in   1      50 MHz system clock
//  sys_rst_n   in   1      asynchronous active-low reset
//  iKey1       in   1      mode key, 1-cycle pulse (debounced press edge)
//  iKey2       in   1      increment key, 1-cycle pulse
//  iKey3       in   1      decrement key, 1-cycle pulse
//  oMode       out  MODE_W current mode index
//  oVal        out  VAL_W  value of slot oMode
//  oUpd        out  1      1-cycle strobe: oMode or oVal changed this cycle
//  oRestore    out  1      1-cycle strobe: all slots restored to VAL_DEF
// BEHAVIOUR
//  Reset (async assert, sync release): oMode=0, all slots=VAL_DEF, oVal=VAL_DEF, oUpd=0, oRestore=0, FSM=IDLE, window counter=0.
//  All outputs are registered. An effect appears on outputs the cycle after the causing pulse (latency 1).
//  Every update in a cycle uses the mode held at the start of that cycle.
//  FSM (key1 click decoder):
//   IDLE: on iKey1 -> WAIT and clear counter. Mode is not changed yet.
//   WAIT: counter increments each cycle.
//    - iKey1 while counter < DCLK_WIN-1 -> double-click:
//      all slots=VAL_DEF, mode unchanged, oRestore=1, oUpd=1, -> IDLE.
//    - counter reaches DCLK_WIN-1 with no iKey1 -> single-click:
//      oMode=(oMode==NUM_MODES-1)?0:oMode+1, oUpd=1, -> IDLE.
//    - iKey1 in the same cycle as timeout counts as double-click (restore wins).
//  Value keys are handled in either FSM state:
//   - iKey2 alone: slot[mode]=min(slot+STEP, VAL_MAX).
//   - iKey3 alone: slot[mode]=max(slot-STEP, 0).
//   - Compute at VAL_W+1 bits so no wrap occurs. Saturation is exact.
//   - iKey2 and iKey3 in the same cycle: both ignored.
//   - oUpd fires only if the slot value actually changes. Presses while saturated give no oUpd.
//  Collisions:
//   - Value step in the cycle of a mode advance: applied to the old mode's slot.
//     The new oMode and that mode's oVal appear together next cycle.
//   - Value step in the cycle of a restore: the restore wins, the step is discarded.
//  oVal always equals slot[oMode] one cycle after any slot or mode change. No glitch or stale value after that cycle.
//  oUpd/oRestore are never high for 2 consecutive cycles from a single event.
//  Reset mid-WAIT: pending click is dropped. No mode advance follows reset.
// TESTING (bench overrides DCLK_WIN=8)
//  1. Reset release: outputs oMode=0, oVal=128, oUpd=0, oRestore=0; hold 20 cycles -> unchanged.
//  2. One iKey1 pulse, none after -> 8 cycles later oMode=1 with a 1-cycle oUpd.
//     Repeat 4x -> oMode=1,2,3,0 (wrap).
//  3. iKey2 x3 in mode 0 -> oVal 129,130,131, each 1 cycle after its pulse.
//     Then iKey3 x200 -> oVal floors at 0, no oUpd once saturated.
//  4. Set slot1=140 via mode 1.
//     iKey1, then iKey1 again 3 cycles later -> oRestore=1 and oUpd=1.
//     Result: oMode still 1, oVal=128, and all slots read 128 after cycling modes.
//  5. iKey2 and iKey3 in the same cycle -> oVal unchanged, oUpd=0.
//     iKey2 in the timeout cycle of mode 0 -> slot0 +1, oMode=1 shows slot1 unchanged.
//  6. Assert sys_rst_n low 3 cycles after iKey1 (mid-WAIT), release -> oMode=0, no later oUpd.
//     With VAL_MAX=130: iKey2 x5 from 128 -> oVal 129,130,130,130,130.

Source files
------------

// File: rtl/key_ctrl.sv
// Key pulse consumer: key1 click decoder (single = next mode, double = restore defaults)
// plus per-mode saturating value stepping on key2/key3.
//   state | meaning
//   IDLE  | no key1 click pending
//   WAIT  | first key1 seen, timing the double-click window
module key_ctrl #(
    parameter int NUM_MODES = 4,
    parameter int MODE_W    = 2,
    parameter int VAL_W     = 8,
    parameter int VAL_MAX   = 255,
    parameter int VAL_DEF   = 128,
    parameter int STEP      = 1,
    parameter int DCLK_WIN  = 15_000_000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              iKey1,
    input  logic              iKey2,
    input  logic              iKey3,
    output logic [MODE_W-1:0] oMode,
    output logic [VAL_W-1:0]  oVal,
    output logic              oUpd,
    output logic              oRestore
);

    localparam int CNT_W = $clog2(DCLK_WIN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DCLK_WIN - 1);
    localparam logic [VAL_W:0]   STEP_X   = (VAL_W+1)'(STEP);
    localparam logic [VAL_W:0]   MAX_X    = (VAL_W+1)'(VAL_MAX);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [VAL_W-1:0]   slot [NUM_MODES];

    logic               restore_ev;
    logic               advance_ev;
    logic [MODE_W-1:0]  mode_next;
    logic [VAL_W-1:0]   cur_val;
    logic [VAL_W:0]     up_x;
    logic [VAL_W-1:0]   step_val;
    logic [VAL_W-1:0]   val_next;

    always_comb begin
        restore_ev = (state == WAIT) && iKey1;
        advance_ev = (state == WAIT) && !iKey1 && (cnt == CNT_LAST);
        mode_next  = oMode;
        if (advance_ev)
            mode_next = (oMode == MODE_W'(NUM_MODES - 1)) ? '0 : oMode + MODE_W'(1);

        cur_val  = slot[oMode];
        up_x     = {1'b0, cur_val} + STEP_X;
        step_val = cur_val;
        if (iKey2 && !iKey3)
            step_val = (up_x > MAX_X) ? VAL_W'(VAL_MAX) : up_x[VAL_W-1:0];
        else if (iKey3 && !iKey2)
            step_val = ({1'b0, cur_val} < STEP_X) ? '0 : cur_val - VAL_W'(STEP);

        // the step lands on the old mode's slot, so the new mode's slot is untouched
        val_next = advance_ev ? slot[mode_next] : step_val;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            oMode    <= '0;
            oVal     <= VAL_W'(VAL_DEF);
            oUpd     <= 1'b0;
            oRestore <= 1'b0;
            for (int i = 0; i < NUM_MODES; i++)
                slot[i] <= VAL_W'(VAL_DEF);
        end else begin
            oUpd     <= 1'b0;
            oRestore <= 1'b0;

            case (state)
                IDLE: begin
                    if (iKey1) begin
                        state <= WAIT;
                        cnt   <= '0;
                    end
                end
                WAIT: begin
                    if (restore_ev || advance_ev)
                        state <= IDLE;
                    else
                        cnt <= cnt + CNT_W'(1);
                end
                default: state <= IDLE;
            endcase

            if (restore_ev) begin
                for (int i = 0; i < NUM_MODES; i++)
                    slot[i] <= VAL_W'(VAL_DEF);
                oVal     <= VAL_W'(VAL_DEF);
                oRestore <= 1'b1;
                oUpd     <= 1'b1;
            end else begin
                slot[oMode] <= step_val;
                oMode       <= mode_next;
                oVal        <= val_next;
                oUpd        <= advance_ev || (step_val != cur_val);
            end
        end
    end

endmodule

// File: tb/tb_key_ctrl.sv
// Scoreboard bench for key_ctrl: two instances (VAL_MAX 255 and 130) share stimulus;
// a cycle-level reference model predicts outputs, a monitor checks them.
module tb_key_ctrl;

    localparam int NM   = 4;
    localparam int DEF  = 128;
    localparam int STP  = 1;
    localparam int DCLK = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       k1 = 1'b0, k2 = 1'b0, k3 = 1'b0;
    logic [1:0] mode_a, mode_b;
    logic [7:0] val_a, val_b;
    logic       upd_a, upd_b, rs_a, rs_b;

    always #5 clk = ~clk;

    key_ctrl #(.NUM_MODES(NM), .MODE_W(2), .VAL_W(8), .VAL_MAX(255), .VAL_DEF(DEF),
               .STEP(STP), .DCLK_WIN(DCLK)) dut_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .iKey1(k1), .iKey2(k2), .iKey3(k3),
        .oMode(mode_a), .oVal(val_a), .oUpd(upd_a), .oRestore(rs_a));

    key_ctrl #(.NUM_MODES(NM), .MODE_W(2), .VAL_W(8), .VAL_MAX(130), .VAL_DEF(DEF),
               .STEP(STP), .DCLK_WIN(DCLK)) dut_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .iKey1(k1), .iKey2(k2), .iKey3(k3),
        .oMode(mode_b), .oVal(val_b), .oUpd(upd_b), .oRestore(rs_b));

    typedef struct {
        int mode [2];
        int val  [2];
        int upd  [2];
        int rs   [2];
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model: click tracked as the cycle number of the first key1
    int vmax [2] = '{255, 130};
    int m_slot [2][NM];
    int m_mode [2];
    int pend;
    int cyc;

    function automatic void model_reset();
        pend = -1;
        cyc  = 0;
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0;
            for (int s = 0; s < NM; s++) m_slot[i][s] = DEF;
        end
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            e.mode[i] = 0; e.val[i] = DEF; e.upd[i] = 0; e.rs[i] = 0;
        end
        return e;
    endfunction

    function automatic exp_t model_step(input bit a, input bit b, input bit c);
        exp_t e;
        bit restore = 0, adv = 0;
        cyc++;
        if (pend < 0) begin
            if (a) pend = cyc;
        end else if (a) begin
            restore = 1; pend = -1;
        end else if (cyc - pend == DCLK) begin
            adv = 1; pend = -1;
        end
        for (int i = 0; i < 2; i++) begin
            int v, nv;
            e.rs[i] = restore;
            if (restore) begin
                for (int s = 0; s < NM; s++) m_slot[i][s] = DEF;
                e.upd[i] = 1;
            end else begin
                v  = m_slot[i][m_mode[i]];
                nv = v;
                if (b && !c) nv = (v + STP > vmax[i]) ? vmax[i] : v + STP;
                if (c && !b) nv = (v - STP < 0) ? 0 : v - STP;
                m_slot[i][m_mode[i]] = nv;
                e.upd[i] = (nv != v || adv) ? 1 : 0;
                if (adv) m_mode[i] = (m_mode[i] + 1) % NM;
            end
            e.mode[i] = m_mode[i];
            e.val[i]  = m_slot[i][m_mode[i]];
        end
        return e;
    endfunction

    task automatic drive(input bit a, input bit b, input bit c);
        @(negedge clk);
        rst_n = 1'b1;
        k1 = a; k2 = b; k3 = c;
        exp_q.push_back(model_step(a, b, c));
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            @(negedge clk);
            rst_n = 1'b0;
            k1 = 0; k2 = 0; k3 = 0;
            model_reset();
            exp_q.push_back(reset_exp());
        end
    endtask

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("mode_a", int'(mode_a), e.mode[0]);
                check("val_a",  int'(val_a),  e.val[0]);
                check("upd_a",  int'(upd_a),  e.upd[0]);
                check("rs_a",   int'(rs_a),   e.rs[0]);
                check("mode_b", int'(mode_b), e.mode[1]);
                check("val_b",  int'(val_b),  e.val[1]);
                check("upd_b",  int'(upd_b),  e.upd[1]);
                check("rs_b",   int'(rs_b),   e.rs[1]);
            end
        end
    end

    initial begin : stim
        int guard;
        model_reset();
        do_reset(3);
        idle(20);

        // single clicks, wrapping through all modes
        repeat (4) begin
            drive(1, 0, 0);
            idle(10);
        end

        // step up then floor at zero
        repeat (3) begin drive(0, 1, 0); idle(1); end
        repeat (200) drive(0, 0, 1);
        idle(2);

        // mode 1, raise slot, then double-click restore
        drive(1, 0, 0);
        idle(9);
        repeat (12) drive(0, 1, 0);
        idle(2);
        drive(1, 0, 0);
        idle(2);
        drive(1, 0, 0);
        idle(3);
        repeat (4) begin drive(1, 0, 0); idle(9); end

        // simultaneous up/down, then a step in the timeout cycle
        drive(0, 1, 1);
        idle(2);
        guard = 0;
        while (m_mode[0] != 0 && guard < 8) begin
            drive(1, 0, 0); idle(9); guard++;
        end
        drive(1, 0, 0);
        idle(DCLK - 1);
        drive(0, 1, 0);
        idle(3);

        // reset in the middle of the window, then ceiling on the VAL_MAX=130 instance
        drive(1, 0, 0);
        idle(2);
        do_reset(2);
        idle(20);
        repeat (5) begin drive(0, 1, 0); idle(1); end

        // randomized traffic
        repeat (2000) begin
            drive($urandom_range(0, 99) < 6, $urandom_range(0, 99) < 25,
                  $urandom_range(0, 99) < 25);
        end
        idle(2);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
